// File: rtl/iosys_pkg.sv
// iosys_pkg: shared state type and image constants for the ROM loader
package iosys_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam logic [31:0] GAME_CODE_OFS = 32'hAC;
  localparam logic [7:0] PAD_BYTE = 8'hFF;
endpackage

// File: rtl/hw_fifo.sv
// hw_fifo: synchronous register FIFO with full/empty flags and same-cycle push/pop
module hw_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign empty = wp == rp;
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign rdata = mem[rp[AW-1:0]];
  // pointers carry an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + ONE;
      if (rd) rp <= rp + ONE;
    end
  end
  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/rom_loader.sv
// rom_loader: streams ROM bytes into SDRAM as little-endian halfword writes
module rom_loader
  import iosys_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   rom_bytes,
  output logic [31:0]       game_code,
  output logic              overflow,
  output logic              fifo_err
);
  localparam int FW = ADDR_W + 15;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  state_t state, state_next;
  logic loading, loading_q, rise, fall, start_pend, pend_valid;
  logic acc, push, pop, full, empty, enter;
  logic [7:0] pend_byte;
  logic [FW-1:0] push_data, head;
  logic [31:0] ofs;
  assign loading = |rom_loading;
  assign rise = loading && !loading_q;
  assign fall = !loading && loading_q;
  assign acc = state == LOAD && rom_do_valid && !rom_bytes[ADDR_W];
  assign push = (acc && rom_bytes[0]) || (state == FLUSH && pend_valid);
  assign push_data = {rom_bytes[ADDR_W-1:1], acc ? rom_do : PAD_BYTE, pend_byte};
  assign pop = mem_valid && mem_ready;
  assign ofs = 32'(rom_bytes);
  assign enter = state_next == LOAD && state != LOAD;

  hw_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .wdata(push_data),
    .pop(pop), .rdata(head), .full(full), .empty(empty)
  );

  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
  // next state and status flags
  always_comb begin
    busy = state == LOAD || state == FLUSH;
    load_done = state == DONE;
    state_next = state == IDLE  ? (rise ? LOAD : IDLE)
               : state == LOAD  ? (fall ? FLUSH : LOAD)
               : state == FLUSH ? (!pend_valid && empty && !mem_valid ? DONE : FLUSH)
               : (start_pend || rise ? LOAD : IDLE);
  end
  // byte accounting: count, even-byte pairing, game code capture, sticky errors, queued restart
  always_ff @(posedge clk) begin
    if (reset) begin
      loading_q <= 1'b0;
      start_pend <= 1'b0;
      pend_valid <= 1'b0;
      pend_byte <= '0;
      rom_bytes <= '0;
      game_code <= '0;
      overflow <= 1'b0;
      fifo_err <= 1'b0;
    end else begin
      loading_q <= loading;
      start_pend <= !enter && (start_pend || (rise && (state == FLUSH || state == DONE)));
      if (enter) begin
        rom_bytes <= '0;
        game_code <= '0;
        overflow <= 1'b0;
        fifo_err <= 1'b0;
        pend_valid <= 1'b0;
      end else begin
        if (acc) rom_bytes <= rom_bytes + ONE;
        if (acc && ofs[31:2] == GAME_CODE_OFS[31:2]) game_code[{ofs[1:0], 3'b000} +: 8] <= rom_do;
        if (acc && !rom_bytes[0]) pend_byte <= rom_do;
        pend_valid <= push ? 1'b0 : (acc && !rom_bytes[0]) ? 1'b1 : pend_valid;
        overflow <= overflow || (state == LOAD && rom_do_valid && rom_bytes[ADDR_W]);
        fifo_err <= fifo_err || (push && full && !pop);
      end
    end
  end
  // write port: present the FIFO head and hold it until mem_ready retires it
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else if (pop) begin
      mem_valid <= 1'b0;
    end else if (!mem_valid && !empty) begin
      mem_valid <= 1'b1;
      mem_addr <= {head[FW-1:16], 1'b0};
      mem_wdata <= head[15:0];
    end
  end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: randomized self-checking bench against an image-level reference model
module tb_rom_loader;
  localparam int AW = 25;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic [1:0] rom_loading = '0;
  logic [7:0] rom_do = '0;
  logic rom_do_valid = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_valid, busy, load_done, overflow, fifo_err;
  logic [AW-1:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [AW:0] rom_bytes;
  logic [31:0] game_code;

  logic [1:0] rom_loading_s = '0;
  logic [7:0] rom_do_s = '0;
  logic rom_do_valid_s = 1'b0;
  logic mem_ready_s = 1'b0;
  logic mem_valid_s, busy_s, load_done_s, overflow_s, fifo_err_s;
  logic [3:0] mem_addr_s;
  logic [15:0] mem_wdata_s;
  logic [4:0] rom_bytes_s;
  logic [31:0] game_code_s;

  rom_loader #(.ADDR_W(AW), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .load_done(load_done),
    .rom_bytes(rom_bytes), .game_code(game_code), .overflow(overflow), .fifo_err(fifo_err)
  );

  rom_loader #(.ADDR_W(4), .FIFO_DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .rom_loading(rom_loading_s), .rom_do(rom_do_s),
    .rom_do_valid(rom_do_valid_s), .mem_valid(mem_valid_s), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .mem_ready(mem_ready_s), .busy(busy_s), .load_done(load_done_s),
    .rom_bytes(rom_bytes_s), .game_code(game_code_s), .overflow(overflow_s), .fifo_err(fifo_err_s)
  );

  typedef struct packed {logic [AW-1:0] a; logic [15:0] d;} wr_t;
  wr_t wq[$];
  wr_t exp_q[$];
  logic [7:0] img [0:1023];
  int passed = 0, total = 0;
  int ready_delay = 3, done_cnt = 0, bad_stable = 0, writes_s = 0;
  bit rand_ready = 1'b0, stall = 1'b0, manual = 1'b0;
  bit prev_v = 1'b0;
  int vcnt = 0, cur_delay = 0;
  wr_t hold;

  // SDRAM responder: records each write, checks stability, answers after a delay
  initial forever begin
    @(negedge clk);
    if (load_done === 1'b1) done_cnt++;
    if (mem_valid === 1'b1 && !prev_v) begin
      hold.a = mem_addr;
      hold.d = mem_wdata;
      wq.push_back(hold);
      vcnt = 0;
      cur_delay = rand_ready ? int'($urandom_range(0, 4)) : ready_delay;
    end else if (mem_valid === 1'b1) begin
      vcnt++;
      if (mem_addr !== hold.a || mem_wdata !== hold.d) bad_stable++;
    end
    if (!manual) mem_ready = mem_valid === 1'b1 && !stall && vcnt >= cur_delay;
    prev_v = mem_valid === 1'b1;
  end

  // responder for the narrow-address instance: immediate acknowledge
  initial forever begin
    @(negedge clk);
    if (mem_valid_s === 1'b1 && !mem_ready_s) writes_s++;
    mem_ready_s = mem_valid_s === 1'b1 && !mem_ready_s;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

  function automatic void build_exp(input int n);
    wr_t w;
    exp_q.delete();
    for (int a = 0; a < n; a += 2) begin
      w.a = AW'(a);
      w.d = {(a + 1 < n) ? img[a+1] : 8'hFF, img[a]};
      exp_q.push_back(w);
    end
  endfunction

  function automatic logic [31:0] exp_gc(input int n);
    logic [31:0] g = '0;
    for (int k = 0; k < 4; k++) if (172 + k < n) g[8*k +: 8] = img[172+k];
    return g;
  endfunction

  function automatic int count_bad();
    int bad = 0;
    foreach (exp_q[i]) if (i >= wq.size() || wq[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  task automatic open_load();
    rom_loading = 2'($urandom_range(1, 3));
    @(negedge clk);
  endtask

  task automatic send(input int from, input int to, input int burst, input int gap, input bit last_drop);
    for (int i = from; i < to; i++) begin
      rom_do = img[i];
      rom_do_valid = 1'b1;
      if (last_drop && i == to - 1) rom_loading = '0;
      @(negedge clk);
      rom_do_valid = 1'b0;
      rom_do = 8'($urandom);
      if ((i + 1 - from) % burst == 0) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int start, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({mem_valid, mem_addr, mem_wdata, busy, load_done, rom_bytes, game_code, overflow, fifo_err} !== '0)
      $display("FAIL reset_outputs got %h want 0", {mem_valid, mem_addr, mem_wdata, busy, load_done, rom_bytes, game_code, overflow, fifo_err});
    else passed++;
    total++;
    if ({mem_valid_s, mem_addr_s, mem_wdata_s, busy_s, load_done_s, rom_bytes_s, game_code_s, overflow_s, fifo_err_s} !== '0)
      $display("FAIL reset_outputs_small got %h want 0", {mem_valid_s, mem_addr_s, mem_wdata_s, busy_s, load_done_s, rom_bytes_s, game_code_s, overflow_s, fifo_err_s});
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_burst();
    bit ok;
    int d0 = done_cnt;
    for (int i = 0; i < 8; i++) img[i] = 8'(i);
    build_exp(8);
    wq.delete();
    rand_ready = 1'b0;
    ready_delay = 3;
    open_load();
    send(0, 8, 4, 6, 1'b0);
    rom_loading = '0;
    wait_done(d0, ok);
    total++;
    if (!ok) $display("FAIL burst_done_timeout got no load_done want one"); else passed++;
    total++;
    if (wq.size() != 4 || count_bad() != 0)
      $display("FAIL burst_writes got %0d writes (first %h) want 4 starting %h", wq.size(), wq.size() > 0 ? wq[0] : '0, exp_q[0]);
    else passed++;
    total++;
    if (rom_bytes !== (AW+1)'(8)) $display("FAIL burst_rom_bytes got %0d want 8", rom_bytes); else passed++;
    total++;
    if (done_cnt != d0 + 1) $display("FAIL burst_done_count got %0d want 1", done_cnt - d0); else passed++;
    total++;
    if (bad_stable != 0) $display("FAIL burst_stable got %0d changes want 0", bad_stable); else passed++;
  endtask

  task automatic test_odd_tail();
    bit ok;
    int d0 = done_cnt;
    for (int i = 0; i < 5; i++) img[i] = 8'($urandom);
    build_exp(5);
    wq.delete();
    open_load();
    total++;
    if (busy !== 1'b1) $display("FAIL odd_busy got %b want 1", busy); else passed++;
    send(0, 5, 1, 1, 1'b0);
    rom_loading = '0;
    wait_done(d0, ok);
    total++;
    if (!ok || wq.size() != 3) $display("FAIL odd_writes got %0d writes (done %b) want 3", wq.size(), ok); else passed++;
    total++;
    if (wq.size() == 3 && wq[2] !== {AW'(4), 8'hFF, img[4]})
      $display("FAIL odd_last got %h want %h", wq[2], {AW'(4), 8'hFF, img[4]});
    else if (wq.size() == 3) passed++;
    else $display("FAIL odd_last got none want %h", {AW'(4), 8'hFF, img[4]});
    total++;
    if (rom_bytes !== (AW+1)'(5)) $display("FAIL odd_rom_bytes got %0d want 5", rom_bytes); else passed++;
    total++;
    if (count_bad() != 0) $display("FAIL odd_data got %0d bad writes want 0", count_bad()); else passed++;
  endtask

  task automatic test_game_code();
    bit ok;
    int d0 = done_cnt;
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    build_exp(256);
    wq.delete();
    rand_ready = 1'b1;
    open_load();
    send(0, 256, 1, 2, 1'b0);
    rom_loading = '0;
    wait_done(d0, ok);
    total++;
    if (game_code !== 32'hAFAEADAC) $display("FAIL gc_value got %h want afaeadac", game_code); else passed++;
    total++;
    if (!ok || wq.size() != 128 || count_bad() != 0)
      $display("FAIL gc_writes got %0d writes (%0d wrong, done %b) want 128", wq.size(), count_bad(), ok);
    else passed++;
    rand_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      bit ok;
      bit drop = 1'($urandom);
      int n = $urandom_range(1, 300);
      int d0 = done_cnt;
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      build_exp(n);
      wq.delete();
      rand_ready = 1'b1;
      open_load();
      send(0, n, 1, $urandom_range(2, 4), drop);
      rom_loading = '0;
      wait_done(d0, ok);
      total++;
      if (!ok || wq.size() != exp_q.size() || count_bad() != 0)
        $display("FAIL rand%0d_writes got %0d writes (%0d wrong, done %b) want %0d", t, wq.size(), count_bad(), ok, exp_q.size());
      else passed++;
      total++;
      if (rom_bytes !== (AW+1)'(n)) $display("FAIL rand%0d_rom_bytes got %0d want %0d", t, rom_bytes, n); else passed++;
      total++;
      if (game_code !== exp_gc(n)) $display("FAIL rand%0d_game_code got %h want %h", t, game_code, exp_gc(n)); else passed++;
      total++;
      if ({overflow, fifo_err} !== 2'b00 || done_cnt != d0 + 1)
        $display("FAIL rand%0d_flags got ovf=%b ferr=%b dones=%0d want 0 0 1", t, overflow, fifo_err, done_cnt - d0);
      else passed++;
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int d0 = done_cnt;
    int n = $urandom_range(20, 60);
    for (int i = 0; i < n; i++) img[i] = 8'($urandom);
    build_exp(n);
    wq.delete();
    ready_delay = 0;
    open_load();
    send(0, n, 1, 0, 1'b1);
    rom_loading = '0;
    wait_done(d0, ok);
    total++;
    if (!ok || wq.size() != exp_q.size() || count_bad() != 0)
      $display("FAIL b2b_writes got %0d writes (%0d wrong, done %b) want %0d", wq.size(), count_bad(), ok, exp_q.size());
    else passed++;
    total++;
    if (fifo_err !== 1'b0) $display("FAIL b2b_fifo_err got %b want 0", fifo_err); else passed++;
    total++;
    if (bad_stable != 0) $display("FAIL b2b_stable got %0d changes want 0", bad_stable); else passed++;
  endtask

  task automatic test_fifo_stall();
    bit ok;
    int bad = 0;
    int d0 = done_cnt;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    wq.delete();
    ready_delay = 1;
    stall = 1'b1;
    open_load();
    send(0, 12, 1, 0, 1'b0);
    repeat (20) @(negedge clk);
    total++;
    if (fifo_err !== 1'b1) $display("FAIL stall_fifo_err got %b want 1", fifo_err); else passed++;
    stall = 1'b0;
    repeat (30) @(negedge clk);
    send(12, 16, 1, 0, 1'b1);
    rom_loading = '0;
    wait_done(d0, ok);
    foreach (wq[i]) if (wq[i].d !== {img[int'(wq[i].a) + 1], img[int'(wq[i].a)]}) bad++;
    total++;
    if (!ok || wq.size() != 6 || bad != 0)
      $display("FAIL stall_writes got %0d writes (%0d wrong, done %b) want 6", wq.size(), bad, ok);
    else passed++;
    total++;
    if (wq.size() > 4 && wq[4].a !== AW'(12)) $display("FAIL stall_skip_addr got %0d want 12", wq[4].a);
    else if (wq.size() > 4) passed++;
    else $display("FAIL stall_skip_addr got none want 12");
    total++;
    if (fifo_err !== 1'b1 || rom_bytes !== (AW+1)'(16))
      $display("FAIL stall_final got ferr=%b bytes=%0d want 1 16", fifo_err, rom_bytes);
    else passed++;
  endtask

  task automatic test_overflow();
    int w0 = writes_s;
    rom_loading_s = 2'd2;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      rom_do_s = 8'(i + 1);
      rom_do_valid_s = 1'b1;
      @(negedge clk);
      rom_do_valid_s = 1'b0;
      repeat (3) @(negedge clk);
    end
    rom_loading_s = '0;
    for (int c = 0; c < 200 && busy_s === 1'b1; c++) @(negedge clk);
    total++;
    if (rom_bytes_s !== 5'd16) $display("FAIL ovf_rom_bytes got %0d want 16", rom_bytes_s); else passed++;
    total++;
    if (overflow_s !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow_s); else passed++;
    total++;
    if (writes_s - w0 != 8) $display("FAIL ovf_writes got %0d want 8", writes_s - w0); else passed++;
    total++;
    if (game_code_s !== 32'h0 || busy_s !== 1'b0) $display("FAIL ovf_misc got gc=%h busy=%b want 0 0", game_code_s, busy_s); else passed++;
  endtask

  task automatic test_latency();
    bit ok;
    int d0 = done_cnt;
    img[0] = 8'($urandom);
    img[1] = 8'($urandom);
    ready_delay = 2;
    open_load();
    send(0, 1, 1, 1, 1'b0);
    rom_do = img[1];
    rom_do_valid = 1'b1;
    @(negedge clk);
    rom_do_valid = 1'b0;
    total++;
    if (mem_valid !== 1'b0) $display("FAIL lat_early got %b want 0", mem_valid); else passed++;
    @(negedge clk);
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== '0 || mem_wdata !== {img[1], img[0]})
      $display("FAIL lat_write got v=%b a=%h d=%h want 1 0 %h", mem_valid, mem_addr, mem_wdata, {img[1], img[0]});
    else passed++;
    rom_loading = '0;
    wait_done(d0, ok);
    total++;
    if (!ok) $display("FAIL lat_done got no load_done want one"); else passed++;
  endtask

  task automatic test_reset_mid_write();
    bit seen = 1'b0;
    manual = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
    open_load();
    send(0, 4, 1, 0, 1'b0);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (mem_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) $display("FAIL midrst_valid got 0 want 1"); else passed++;
    reset = 1'b1;
    rom_loading = '0;
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    total++;
    if ({mem_valid, mem_addr, mem_wdata, busy, load_done, rom_bytes, game_code, overflow, fifo_err} !== '0)
      $display("FAIL midrst_outputs got %h want 0", {mem_valid, mem_addr, mem_wdata, busy, load_done, rom_bytes, game_code, overflow, fifo_err});
    else passed++;
    repeat (6) @(negedge clk);
    total++;
    if (mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_quiet got v=%b busy=%b want 0 0", mem_valid, busy); else passed++;
    manual = 1'b0;
  endtask

  task automatic test_reset_release();
    bit ok;
    int d0 = done_cnt;
    wq.delete();
    reset = 1'b1;
    rom_loading = 2'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) $display("FAIL rel_start busy got %b want 1", busy); else passed++;
    rom_loading = '0;
    wait_done(d0, ok);
    total++;
    if (!ok || wq.size() != 0 || rom_bytes !== '0)
      $display("FAIL rel_empty got done=%b writes=%0d bytes=%0d want 1 0 0", ok, wq.size(), rom_bytes);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_odd_tail();
    test_latency();
    test_game_code();
    test_random();
    test_back_to_back();
    test_fifo_stall();
    test_overflow();
    test_reset_mid_write();
    test_reset_release();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
